// File: rtl/vga_console.sv
// Byte-stream text console driving the VGA character buffer write port.
// Define VGA_CONSOLE_CLEAR_ON_RESET_EN to blank the whole buffer after every reset.
module vga_console #(
  parameter  int CHAR_ROWS = 12,
  parameter  int CHAR_COLS = 8,
  localparam int COLS      = 640 / CHAR_COLS,
  localparam int ROWS      = 480 / CHAR_ROWS,
  localparam int AW        = $clog2(COLS * ROWS),
  localparam int CW        = $clog2(COLS),
  localparam int RW        = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  output logic          buf_we,
  output logic [AW-1:0] buf_addr,
  output logic [6:0]    buf_data,
  output logic [CW-1:0] cursor_col,
  output logic [RW-1:0] cursor_row
);

  typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_ALL} state_t;

`ifdef VGA_CONSOLE_CLEAR_ON_RESET_EN
  localparam state_t RST_STATE = CLR_ALL;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  localparam logic [AW-1:0] COLS_A    = AW'(COLS);
  localparam logic [AW-1:0] LINE_LAST = AW'(COLS - 1);
  localparam logic [AW-1:0] ALL_LAST  = AW'(COLS * ROWS - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [6:0]    SPACE     = 7'h20;

  state_t        state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;
  logic [CW-1:0] col_nx, col_dec;
  logic [RW-1:0] row_nx, row_inc;
  logic [AW-1:0] row_base, inc_base, addr_nx;
  logic [6:0]    data_nx;
  logic          we_nx, printable;

  assign in_ready  = (state == IDLE);
  assign row_inc   = (cursor_row == ROW_LAST) ? '0 : cursor_row + RW'(1);
  assign col_dec   = cursor_col - CW'(1);
  assign row_base  = AW'(cursor_row) * COLS_A;
  assign inc_base  = AW'(row_inc) * COLS_A;
  assign printable = (in_data >= 8'h20) && (in_data <= 8'h7e);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RST_STATE;
      cnt        <= '0;
      buf_we     <= 1'b0;
      buf_addr   <= '0;
      buf_data   <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      buf_we     <= we_nx;
      buf_addr   <= addr_nx;
      buf_data   <= data_nx;
      cursor_col <= col_nx;
      cursor_row <= row_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    we_nx    = 1'b0;
    addr_nx  = buf_addr;
    data_nx  = buf_data;
    col_nx   = cursor_col;
    row_nx   = cursor_row;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          if (printable) begin
            we_nx   = 1'b1;
            addr_nx = row_base + AW'(cursor_col);
            data_nx = in_data[6:0];
            if (cursor_col == COL_LAST) begin
              // character lands on the old row; the new row is blanked next
              col_nx   = '0;
              row_nx   = row_inc;
              cnt_nx   = '0;
              state_nx = CLR_LINE;
            end else begin
              col_nx = cursor_col + CW'(1);
            end
          end else begin
            case (in_data)
              8'h0a: begin
                // first blank of the new row goes out with the accept itself
                col_nx   = '0;
                row_nx   = row_inc;
                we_nx    = 1'b1;
                addr_nx  = inc_base;
                data_nx  = SPACE;
                cnt_nx   = AW'(1);
                state_nx = CLR_LINE;
              end
              8'h0d: col_nx = '0;
              8'h08: begin
                if (cursor_col != '0) begin
                  col_nx  = col_dec;
                  we_nx   = 1'b1;
                  addr_nx = row_base + AW'(col_dec);
                  data_nx = SPACE;
                end
              end
              8'h0c: begin
                col_nx   = '0;
                row_nx   = '0;
                we_nx    = 1'b1;
                addr_nx  = '0;
                data_nx  = SPACE;
                cnt_nx   = AW'(1);
                state_nx = CLR_ALL;
              end
              default: ;
            endcase
          end
        end
      end
      CLR_LINE: begin
        we_nx   = 1'b1;
        addr_nx = row_base + cnt;
        data_nx = SPACE;
        cnt_nx  = cnt + AW'(1);
        if (cnt == LINE_LAST) state_nx = IDLE;
      end
      CLR_ALL: begin
        we_nx   = 1'b1;
        addr_nx = cnt;
        data_nx = SPACE;
        cnt_nx  = cnt + AW'(1);
        if (cnt == ALL_LAST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vga_console.sv
// Random byte stream against a queue-based console model, plus literal checks.
module tb_vga_console;
  localparam int COLS = 80;
  localparam int ROWS = 40;
  localparam int AW   = 12;
  localparam int CW   = 7;
  localparam int RW   = 6;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data  = 8'h00;
  logic          in_ready, buf_we;
  logic [AW-1:0] buf_addr;
  logic [6:0]    buf_data;
  logic [CW-1:0] cursor_col;
  logic [RW-1:0] cursor_row;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  vga_console dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_data(buf_data),
    .cursor_col(cursor_col), .cursor_row(cursor_row)
  );

  always #5 clk = ~clk;

  // Model: a queue of pending blank writes; ready whenever the queue is empty.
  int   sched[$];
  int   m_col, m_row, e_addr, e_data;
  bit   e_we, e_full, m_ready, acc;
  logic [7:0] mb;

  function automatic void model_reset();
    sched.delete();
`ifdef VGA_CONSOLE_CLEAR_ON_RESET_EN
    for (int i = 0; i < COLS * ROWS; i++) sched.push_back(i);
`endif
    m_col = 0; m_row = 0;
    e_we = 1'b0; e_full = 1'b1; e_addr = 0; e_data = 0;
    m_ready = (sched.size() == 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else begin
      acc = in_valid && (sched.size() == 0);
      mb  = in_data;
      e_we = 1'b0; e_full = 1'b0;
      if (sched.size() != 0) begin
        e_we = 1'b1; e_addr = sched.pop_front(); e_data = 'h20;
      end else if (acc) begin
        if (mb >= 8'h20 && mb <= 8'h7e) begin
          e_we = 1'b1; e_addr = m_row * COLS + m_col; e_data = int'(mb[6:0]);
          if (m_col == COLS - 1) begin
            m_col = 0; m_row = (m_row + 1) % ROWS;
            for (int i = 0; i < COLS; i++) sched.push_back(m_row * COLS + i);
          end else m_col++;
        end else if (mb == 8'h0a) begin
          m_col = 0; m_row = (m_row + 1) % ROWS;
          e_we = 1'b1; e_addr = m_row * COLS; e_data = 'h20;
          for (int i = 1; i < COLS; i++) sched.push_back(m_row * COLS + i);
        end else if (mb == 8'h0d) begin
          m_col = 0;
        end else if (mb == 8'h08) begin
          if (m_col > 0) begin
            m_col--; e_we = 1'b1; e_addr = m_row * COLS + m_col; e_data = 'h20;
          end
        end else if (mb == 8'h0c) begin
          m_col = 0; m_row = 0;
          e_we = 1'b1; e_addr = 0; e_data = 'h20;
          for (int i = 1; i < COLS * ROWS; i++) sched.push_back(i);
        end
      end
      m_ready = (sched.size() == 0);
    end
  end

  bit ok;
  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      ok = (buf_we === e_we) && (in_ready === m_ready) &&
           (int'(cursor_col) == m_col) && (int'(cursor_row) == m_row);
      if (e_we || e_full) ok = ok && (int'(buf_addr) == e_addr) && (int'(buf_data) == e_data);
      if (!ok) begin
        n_err++;
        if (n_err <= 20)
          $display("FAIL model t=%0t: we %0b/%0b addr %0d/%0d data %02h/%02h rdy %0b/%0b col %0d/%0d row %0d/%0d",
                   $time, buf_we, e_we, buf_addr, e_addr, buf_data, e_data, in_ready, m_ready,
                   cursor_col, m_col, cursor_row, m_row);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = b;
    while (!in_ready && n < 5000) begin @(negedge clk); n++; end
    if (!in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: byte %02h got not-ready expected ready", b);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(output int writes, output int low, output int last);
    writes = 0; low = 0; last = -1;
    for (int n = 0; n < 5000; n++) begin
      if (buf_we && buf_data == 7'h20) begin writes++; last = int'(buf_addr); end
      if (in_ready) return;
      low++;
      @(negedge clk);
    end
    n_cmp++; n_err++;
    $display("FAIL drain_timeout: got busy expected ready within 5000 cycles");
  endtask

  initial begin
    int w, l, la, r;
    logic [7:0] b;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_we", int'(buf_we), 0);
    chk("rst_addr", int'(buf_addr), 0);
    chk("rst_data", int'(buf_data), 0);
    chk("rst_col", int'(cursor_col), 0);
`ifdef VGA_CONSOLE_CLEAR_ON_RESET_EN
    chk("rst_ready", int'(in_ready), 0);
    @(negedge clk); rst_n = 1'b1;
    drain(w, l, la);
    chk("por_writes", w, 3200);
    chk("por_last", la, 3199);
`else
    chk("rst_ready", int'(in_ready), 1);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_no_write", int'(buf_we), 0);
`endif

    send(8'h41);
    chk("A_we", int'(buf_we), 1);
    chk("A_addr", int'(buf_addr), 0);
    chk("A_data", int'(buf_data), 'h41);
    chk("A_col", int'(cursor_col), 1);
    chk("A_row", int'(cursor_row), 0);
    @(negedge clk);
    chk("A_we_drop", int'(buf_we), 0);
    send(8'h0d);
    chk("cr_col", int'(cursor_col), 0);

    for (int i = 0; i < COLS; i++) send(8'h78);
    chk("wrap_char_addr", int'(buf_addr), 79);
    drain(w, l, la);
    chk("wrap_ready_low", l, 80);
    chk("wrap_writes", w, 80);
    chk("wrap_last", la, 159);
    chk("wrap_col", int'(cursor_col), 0);
    chk("wrap_row", int'(cursor_row), 1);

    repeat (2) begin send(8'h0a); drain(w, l, la); end
    repeat (5) send(8'(32'h21 + $urandom_range(0, 93)));
    send(8'h08);
    chk("bs_we", int'(buf_we), 1);
    chk("bs_addr", int'(buf_addr), 244);
    chk("bs_data", int'(buf_data), 'h20);
    chk("bs_col", int'(cursor_col), 4);
    send(8'h0d);
    send(8'h08);
    chk("bs0_we", int'(buf_we), 0);
    chk("bs0_col", int'(cursor_col), 0);
    chk("bs0_row", int'(cursor_row), 3);

    repeat (36) begin send(8'h0a); drain(w, l, la); end
    repeat (10) send(8'(32'h21 + $urandom_range(0, 93)));
    chk("pre_lf_row", int'(cursor_row), 39);
    send(8'h0a);
    drain(w, l, la);
    chk("lf_writes", w, 80);
    chk("lf_last", la, 79);
    chk("lf_row", int'(cursor_row), 0);
    send(8'h0d);
    chk("cr_we", int'(buf_we), 0);

    send(8'h0c);
    in_valid = 1'b1; in_data = 8'h42;
    drain(w, l, la);
    chk("ff_writes", w, 3200);
    chk("ff_last", la, 3199);
    @(negedge clk);
    in_valid = 1'b0;
    chk("B_we", int'(buf_we), 1);
    chk("B_addr", int'(buf_addr), 0);
    chk("B_data", int'(buf_data), 'h42);

    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      b = 8'(32'h20 + $urandom_range(0, 94));
      else if (r < 67) b = 8'h0a;
      else if (r < 75) b = 8'h0d;
      else if (r < 87) b = 8'h08;
      else if (r < 88) b = 8'h0c;
      else             b = 8'($urandom_range(0, 255));
      send(b);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    if (!in_ready) drain(w, l, la);

    send(8'h0c);
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_we", int'(buf_we), 0);
    chk("mr_addr", int'(buf_addr), 0);
    chk("mr_col", int'(cursor_col), 0);
    chk("mr_row", int'(cursor_row), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
`ifdef VGA_CONSOLE_CLEAR_ON_RESET_EN
    drain(w, l, la);
    chk("mr_por_writes", w, 3200);
`else
    repeat (5) @(negedge clk);
    chk("mr_no_write", int'(buf_we), 0);
    chk("mr_ready", int'(in_ready), 1);
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
